// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_e : controller FSM encoding (idle / run / done)
//   cnt_w() : bit-counter width for a given operand width, never below 1
package serial_arith_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // $clog2(1) is 0, so small widths still get a 1-bit counter.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_cell.sv
// Combinational 1-bit full adder built from two half-add stages.
// Ports:
//   a_i, b_i  operand bits
//   cin_i     carry in
//   s_o       sum bit
//   cout_o    carry out (majority of a_i, b_i, cin_i)
module serial_add_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  logic h1_s, h1_c, h2_c;

  // First half-add: operand bits.
  assign h1_s = a_i ^ b_i;
  assign h1_c = a_i & b_i;

  // Second half-add: fold in the carry.
  assign s_o  = h1_s ^ cin_i;
  assign h2_c = h1_s & cin_i;

  assign cout_o = h1_c | h2_c;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. Accepts two Width-bit operands on a valid/ready
// handshake, adds one bit per clock (LSB first) through a shared 1-bit cell, then
// presents sum and carry out on an output handshake.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active high
//   in_valid_i   operands valid
//   in_ready_o   operands can be accepted (idle only)
//   a_i, b_i     operands
//   out_valid_o  result valid (done only)
//   out_ready_i  consumer accepts result
//   sum_o        a + b modulo 2^Width
//   carry_out_o  carry out of bit Width-1
module serial_adder_ctrl
  import serial_arith_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] sum_o,
  output logic             carry_out_o
);

  localparam int unsigned     CntW    = cnt_w(Width);
  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  state_e           state_q;
  logic [Width-1:0] a_q, b_q, sh_q, sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, co_q, in_ready_q, out_valid_q;

  logic             cell_s, cell_c;
  logic [Width-1:0] sh_d;

  serial_add_cell u_cell (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .s_o    (cell_s),
    .cout_o (cell_c)
  );

  // New sum bit enters at the MSB end; after Width shifts bit 0 holds the LSB.
  always_comb begin
    sh_d          = sh_q >> 1;
    sh_d[Width-1] = cell_s;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sh_q        <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      co_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Ready rises on the first clock after reset release.
          in_ready_q <= 1'b1;
          if (in_valid_i && in_ready_q) begin
            state_q    <= StRun;
            a_q        <= a_i;
            b_q        <= b_i;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
          end
        end
        StRun: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= cell_c;
          sh_q    <= sh_d;
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_q     <= StDone;
            sum_q       <= sh_d;
            co_q        <= cell_c;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign sum_o       = sum_q;
  assign carry_out_o = co_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (Width = 8): directed cases followed by
// 1000 random operations with random input gaps and output backpressure. Expected
// results are pushed at each accepted handshake and popped at each consumed result.
module tb_serial_adder_ctrl;

  localparam int unsigned Width = 8;
  localparam int          NOps  = 1000;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] a, b;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] sum;
  logic             carry_out;

  logic [Width:0] sb[$];
  int             n_checks = 0;
  int             n_pass   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(
    .Width (Width)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .carry_out_o (carry_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One directed operation. hold = cycles of out_ready=0 in done; poke keeps
  // in_valid high with a different operand while busy.
  task automatic run_op(input logic [Width-1:0] op_a, input logic [Width-1:0] op_b,
                        input int hold, input bit poke);
    int             cyc;
    logic [Width:0] snap;
    logic [Width:0] exp;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      step();
      cyc++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a        = op_a;
    b        = op_b;
    in_valid = 1'b1;
    sb.push_back({1'b0, op_a} + {1'b0, op_b});
    step();
    if (poke) begin
      a = 8'h11;
      b = 8'h11;
    end else begin
      in_valid = 1'b0;
    end
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      check("in_ready_run", 32'(in_ready), 32'd0);
      step();
      cyc++;
    end
    check("latency", 32'(cyc), 32'(Width));
    snap = {carry_out, sum};
    for (int i = 0; i < hold; i++) begin
      check("in_ready_done", 32'(in_ready), 32'd0);
      step();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'({carry_out, sum}), 32'(snap));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      check("result", 32'({carry_out, sum}), 32'(exp));
    end
    step();
    out_ready = 1'b0;
    check("out_valid_clear", 32'(out_valid), 32'd0);
    check("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'({carry_out, sum}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_in_ready_low", 32'(in_ready), 32'd0);
    step();
    check("rel_in_ready_high", 32'(in_ready), 32'd1);

    // Zero, full ripple, complementary bits, top-bit overflow.
    run_op(8'h00, 8'h00, 0, 1'b0);
    run_op(8'hFF, 8'h01, 0, 1'b0);
    run_op(8'hA5, 8'h5A, 0, 1'b0);
    run_op(8'h80, 8'h80, 0, 1'b0);
    // Backpressure with ignored operands while busy.
    run_op(8'h3C, 8'h21, 5, 1'b1);

    // Reset mid-run: result register still holds 8'h5D beforehand.
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      step();
      cyc++;
    end
    a        = 8'h12;
    b        = 8'h34;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'({carry_out, sum}), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_rel_in_ready_low", 32'(in_ready), 32'd0);
    step();
    check("abort_rel_in_ready_high", 32'(in_ready), 32'd1);
    check("abort_no_result", 32'(out_valid), 32'd0);
    run_op(8'h03, 8'h04, 0, 1'b0);

    // Random traffic: independent producer and consumer.
    fork
      begin : producer
        int wcyc;
        logic [Width-1:0] ra, rb;
        for (int i = 0; i < NOps; i++) begin
          repeat ($urandom_range(0, 3)) step();
          ra       = Width'($urandom);
          rb       = Width'($urandom);
          a        = ra;
          b        = rb;
          in_valid = 1'b1;
          wcyc     = 0;
          while (!in_ready && wcyc < 100) begin
            step();
            wcyc++;
          end
          if (wcyc >= 100) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            break;
          end
          sb.push_back({1'b0, ra} + {1'b0, rb});
          step();
          in_valid = 1'b0;
        end
      end
      begin : consumer
        int got;
        int ccyc;
        got  = 0;
        ccyc = 0;
        while (got < NOps && ccyc < 40000) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            if (sb.size() == 0) check("dup_result", 32'd1, 32'd0);
            else check("rand_result", 32'({carry_out, sum}), 32'(sb.pop_front()));
            got++;
          end
          step();
          ccyc++;
        end
        out_ready = 1'b0;
        check("rand_count", 32'(got), 32'(NOps));
      end
    join
    repeat (12) step();
    check("no_extra_valid", 32'(out_valid), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
